// File: rtl/gate_eval_pkg.sv
// Shared definitions for the gate evaluator family: op encoding and its width.
package gate_eval_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_BUF  = 3'd0,
    OP_NOT  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

endpackage

// File: rtl/gate_reduce.sv
// Combinational bitwise reduction of NUM_IN lanes through one primitive gate.
module gate_reduce
  import gate_eval_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 3
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  op_e                     op,
  output logic [WIDTH-1:0]        result
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;
  logic [WIDTH-1:0] lane0;

  assign lane0 = data[WIDTH-1:0];

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      and_r = and_r & data[k*WIDTH +: WIDTH];
      or_r  = or_r  | data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    result = lane0;
    case (op)
      OP_BUF:  result = lane0;
      OP_NOT:  result = ~lane0;
      OP_AND:  result = and_r;
      OP_OR:   result = or_r;
      OP_NAND: result = ~and_r;
      OP_NOR:  result = ~or_r;
      OP_XOR:  result = xor_r;
      OP_XNOR: result = ~xor_r;
      default: result = lane0;
    endcase
  end

endmodule

// File: rtl/gate_pipe_eval.sv
// Pipelined gate evaluator: reduce accepted word, carry it through STAGES
// valid/ready registers, and count output toggles for activity statistics.
module gate_pipe_eval
  import gate_eval_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 3,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]         op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        toggle_cnt
);

  // Handshake: a word moves on a side when valid & ready are both high in the
  // same cycle; valid never waits on ready, and data is held stable while
  // valid is high and ready is low.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  gate_result;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_load;
  logic [WIDTH-1:0]  stage_data [STAGES];

  gate_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .data   (in_data),
    .op     (op_e'(op)),
    .result (gate_result)
  );

  // A stage can load when the sink takes a word or any stage from here to the
  // output is empty; this is the unrolled form of !valid | next_loads.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             v_q;
    logic [WIDTH-1:0] d_q;
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (i == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = gate_result;
    end else begin : g_body
      assign src_v = stage_valid[i-1];
      assign src_d = stage_data[i-1];
    end

    assign stage_load[i] = out_ready | ~(&stage_valid[STAGES-1:i]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (stage_load[i]) begin
        v_q <= src_v;
        if (src_v) begin
          d_q <= src_d;
        end
      end
    end

    assign stage_valid[i] = v_q;
    assign stage_data[i]  = d_q;
  end

  assign in_ready  = stage_load[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];

  logic             out_xfer;
  logic             toggled;
  logic [WIDTH-1:0] last_out;

  assign out_xfer = out_valid & out_ready;
  assign toggled  = out_xfer & (out_data != last_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_out <= '0;
    end else if (out_xfer) begin
      last_out <= out_data;
    end
  end

  // Clear has priority over a same-cycle toggle; the counter sticks at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_cnt <= '0;
    end else if (cnt_clr) begin
      toggle_cnt <= '0;
    end else if (toggled && (toggle_cnt != CNT_MAX)) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gate_pipe_eval.sv
// Bench for gate_pipe_eval: default instance checked against a reference model
// every cycle, plus small instances for counter saturation and wide parity.
module tb_gate_pipe_eval;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- default instance ----------------
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
  logic [2:0]  a_in_data, a_op;
  logic [0:0]  a_out_data;
  logic [15:0] a_toggle_cnt;

  gate_pipe_eval u_def (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_data    (a_in_data),
    .op         (a_op),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_data   (a_out_data),
    .cnt_clr    (a_cnt_clr),
    .toggle_cnt (a_toggle_cnt)
  );

  // ---------------- CNT_W = 2 instance ----------------
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clr;
  logic [2:0] s_in_data, s_op;
  logic [0:0] s_out_data;
  logic [1:0] s_toggle_cnt;

  gate_pipe_eval #(.CNT_W(2)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_data    (s_in_data),
    .op         (s_op),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_data   (s_out_data),
    .cnt_clr    (s_cnt_clr),
    .toggle_cnt (s_toggle_cnt)
  );

  // ---------------- wide instance ----------------
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_cnt_clr;
  logic [39:0] w_in_data;
  logic [2:0]  w_op;
  logic [7:0]  w_out_data;
  logic [15:0] w_toggle_cnt;

  gate_pipe_eval #(.WIDTH(8), .NUM_IN(5), .STAGES(4)) u_wide (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (w_in_valid),
    .in_ready   (w_in_ready),
    .in_data    (w_in_data),
    .op         (w_op),
    .out_valid  (w_out_valid),
    .out_ready  (w_out_ready),
    .out_data   (w_out_data),
    .cnt_clr    (w_cnt_clr),
    .toggle_cnt (w_toggle_cnt)
  );

  // ---------------- reference model ----------------
  function automatic logic [0:0] gate_ref(input logic [2:0] op_v, input logic [2:0] d);
    int ones;
    ones = int'(d[0]) + int'(d[1]) + int'(d[2]);
    case (op_v)
      3'd0:    return d[0];
      3'd1:    return ~d[0];
      3'd2:    return (ones == 3);
      3'd3:    return (ones != 0);
      3'd4:    return (ones != 3);
      3'd5:    return (ones == 0);
      3'd6:    return ((ones % 2) == 1);
      default: return ((ones % 2) == 0);
    endcase
  endfunction

  logic [0:0] exp_q[$];
  logic [0:0] mdl_last;
  int         mdl_cnt;
  logic       held_valid;
  logic [0:0] held_data;
  bit         expect_ready_on = 1'b0;

  // Compare process for the default instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_last   = 1'b0;
      mdl_cnt    = 0;
      held_valid = 1'b0;
    end else begin
      logic [0:0] exp_v;
      logic       tog;
      check("toggle_cnt", 64'(a_toggle_cnt), 64'(mdl_cnt));
      if (held_valid && a_out_valid) check("stall_stable", 64'(a_out_data), 64'(held_data));
      if (expect_ready_on) check("stream_in_ready", 64'(a_in_ready), 64'd1);
      tog = 1'b0;
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(a_out_valid), 64'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("out_data", 64'(a_out_data), 64'(exp_v));
          tog      = (exp_v != mdl_last);
          mdl_last = exp_v;
        end
      end
      if (a_cnt_clr) mdl_cnt = 0;
      else if (tog && mdl_cnt < 65535) mdl_cnt++;
      held_valid = a_out_valid && !a_out_ready;
      held_data  = a_out_data;
      if (a_in_valid && a_in_ready) exp_q.push_back(gate_ref(a_op, a_in_data));
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_a(input logic [2:0] op_v, input logic [2:0] d);
    int guard;
    guard      = 0;
    a_in_valid = 1'b1;
    a_op       = op_v;
    a_in_data  = d;
    @(negedge clk);
    while (!a_in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_timeout", 64'(guard < 50), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain_a();
    int guard;
    guard      = 0;
    a_in_valid = 1'b0;
    while ((exp_q.size() != 0 || a_out_valid) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int seen;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_op = 0; a_out_ready = 1; a_cnt_clr = 0;
    s_in_valid = 0; s_in_data = 0; s_op = 0; s_out_ready = 1; s_cnt_clr = 0;
    w_in_valid = 0; w_in_data = 0; w_op = 0; w_out_ready = 1; w_cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_data", 64'(a_out_data), 64'd0);
    check("rst_toggle_cnt", 64'(a_toggle_cnt), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_wide_in_ready", 64'(w_in_ready), 64'd1);
    @(posedge clk); #1;

    // XNOR of {c,b,a}=011 -> 1, visible two cycles after accept
    a_in_valid = 1; a_op = 3'd7; a_in_data = 3'b011;
    @(posedge clk); #1;
    a_in_valid = 0;
    cycles = 1;
    @(negedge clk);
    while (!a_out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("xnor_latency", 64'(cycles), 64'd2);
    check("xnor_literal", 64'(a_out_data), 64'd1);
    @(posedge clk); #1;
    send_a(3'd4, 3'b111);
    a_in_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("nand_literal", 64'(a_out_data), 64'd0);
    @(posedge clk); #1;
    drain_a();

    // All ops x all inputs back to back
    expect_ready_on = 1'b1;
    for (int o = 0; o < 8; o++)
      for (int v = 0; v < 8; v++)
        send_a(3'(o), 3'(v));
    expect_ready_on = 1'b0;

    // Stall with a full pipeline, then release
    send_a(3'd3, 3'b100);
    send_a(3'd0, 3'b000);
    a_in_valid = 1; a_op = 3'd1; a_in_data = 3'b000;
    a_out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(a_in_ready), 64'd0);
      @(posedge clk); #1;
    end
    a_out_ready = 1;
    @(negedge clk);
    check("release_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    send_a(3'd2, 3'b111);
    send_a(3'd5, 3'b000);
    drain_a();

    // Toggle counting from a clean reset
    rst = 1; @(posedge clk); #1; rst = 0;
    send_a(3'd0, 3'b000);
    send_a(3'd0, 3'b001);
    send_a(3'd0, 3'b000);
    send_a(3'd0, 3'b001);
    drain_a();
    @(negedge clk);
    check("toggle_literal", 64'(a_toggle_cnt), 64'd3);
    @(posedge clk); #1;
    send_a(3'd0, 3'b000);
    a_in_valid = 0;
    @(posedge clk); #1;
    a_cnt_clr = 1;
    @(posedge clk); #1;
    a_cnt_clr = 0;
    @(negedge clk);
    check("clr_wins", 64'(a_toggle_cnt), 64'd0);
    @(posedge clk); #1;
    send_a(3'd0, 3'b001);
    drain_a();
    @(negedge clk);
    check("clr_keeps_last", 64'(a_toggle_cnt), 64'd1);
    @(posedge clk); #1;

    // Reset with two words in flight
    send_a(3'd0, 3'b001);
    send_a(3'd1, 3'b000);
    a_in_valid = 0;
    rst = 1;
    @(negedge clk);
    check("midrst_out_valid", 64'(a_out_valid), 64'd0);
    check("midrst_toggle_cnt", 64'(a_toggle_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    check("no_stale", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // CNT_W=2: transfers 0,1,0,1,0,1 give five toggles, saturating at 3
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1; s_op = 3'd0; s_in_data = {2'b00, 1'(i % 2)};
      @(negedge clk);
      check("sat_in_ready", 64'(s_in_ready), 64'd1);
      @(posedge clk); #1;
    end
    s_in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("sat_cnt", 64'(s_toggle_cnt), 64'd3);
    check("sat_last_data", 64'(s_out_data), 64'd1);
    check("sat_out_valid", 64'(s_out_valid), 64'd0);
    @(posedge clk); #1;

    // Wide: XOR of 01,02,04,08,F0 = FF; then AND of B3,FF,7F,37,F3 = 33
    w_in_valid = 1; w_op = 3'd6; w_in_data = {8'hF0, 8'h08, 8'h04, 8'h02, 8'h01};
    @(posedge clk); #1;
    w_op = 3'd2; w_in_data = {8'hB3, 8'hFF, 8'h7F, 8'h37, 8'hF3};
    @(posedge clk); #1;
    w_in_valid = 0;
    @(negedge clk);
    check("wide_early_2", 64'(w_out_valid), 64'd0);
    @(negedge clk);
    check("wide_early_3", 64'(w_out_valid), 64'd0);
    @(negedge clk);
    check("wide_valid_4", 64'(w_out_valid), 64'd1);
    check("wide_xor", 64'(w_out_data), 64'hFF);
    @(negedge clk);
    check("wide_valid_5", 64'(w_out_valid), 64'd1);
    check("wide_and", 64'(w_out_data), 64'h33);
    @(negedge clk);
    check("wide_idle", 64'(w_out_valid), 64'd0);
    check("wide_toggle_cnt", 64'(w_toggle_cnt), 64'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
